game_timer: RTL and testbench
=============================

GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 50000000, clock cycles per game second; legal range 2..2^26.
REQ-002 Parameter HARD_LIMIT, default 8'h30, two-digit BCD start time for hard.
REQ-003 Parameter MEDIUM_LIMIT, default 8'h60, two-digit BCD start time for medium.
REQ-004 Parameter EASY_LIMIT, default 8'h99, two-digit BCD start time for easy; each limit is legal BCD in 01..99.
REQ-005 clock  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 playHard  input  1  level; hard game in progress.
REQ-008 playMedium  input  1  level; medium game in progress.
REQ-009 playEasy  input  1  level; easy game in progress.
REQ-010 externalReset  input  1  one-cycle game-over pulse from the difficulty controller.
REQ-011 mazeDone  input  1  level or pulse; player has reached the maze exit.
REQ-012 timeBCD  output  8  remaining seconds, [7:4] tens, [3:0] ones, BCD.
REQ-013 tick  output  1  one-cycle pulse on each game-second decrement.
REQ-014 running  output  1  high while the countdown is active.
REQ-015 timeUp  output  1  level; game lost on timeout.
REQ-016 win  output  1  level; maze finished before timeout.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, RUN, WIN, LOSE; all outputs are registered.
REQ-018 IDLE: exactly one play* high -> LOAD, latching that difficulty; zero or more than one high -> stay IDLE.
REQ-019 LOAD (one cycle): timeBCD <= latched limit, prescaler <= 0; -> RUN.
REQ-020 RUN: running = 1; prescaler counts 0..TICKS_PER_SEC-1 and wraps to 0.
REQ-021 The prescaler wrap cycle SHALL pulse tick for one cycle and decrement timeBCD by 1 in BCD: ones 0 -> 9 with tens - 1; otherwise ones - 1.
REQ-022 A decrement producing 8'h00 SHALL go to LOSE on that edge; timeBCD then shows 00.
REQ-023 mazeDone high in RUN -> WIN; timeBCD frozen at its pre-edge value; no tick in that cycle, even if the prescaler wraps in the same cycle.
REQ-024 WIN: win = 1. LOSE: timeUp = 1. In both: running = 0, tick = 0, timeBCD held, prescaler idle.
REQ-025 Priority in every non-IDLE state SHALL be: externalReset, then latched play* deasserted, then mazeDone, then prescaler wrap.
REQ-026 externalReset high or latched play* low in any non-IDLE state -> IDLE on the next edge.
REQ-027 On entering IDLE, timeBCD, win and timeUp SHALL clear to 0.
REQ-028 Other play* inputs changing while not in IDLE SHALL be ignored.
REQ-029 mazeDone SHALL be ignored in IDLE, LOAD, WIN and LOSE.
REQ-030 Latency from a single play* rising to running = 1 SHALL be 2 cycles: IDLE -> LOAD, then LOAD -> RUN.
REQ-031 The first tick SHALL occur TICKS_PER_SEC cycles after entering RUN.

Reset
REQ-032 reset high SHALL immediately force: state IDLE, prescaler 0, latched difficulty cleared, timeBCD 8'h00, tick/running/timeUp/win 0.
REQ-033 reset asserted mid-RUN SHALL abandon the game; after release the block waits in IDLE for a fresh single play* level.
REQ-034 Release of reset SHALL be used synchronously; the first transition occurs no earlier than the first rising edge after release.

Verification (TICKS_PER_SEC = 4, default limits)
REQ-035 playHard=1 from IDLE -> running=1 after 2 cycles, timeBCD=8'h30; tick every 4 cycles; timeBCD 30->29->28.
REQ-036 playEasy held 99 s -> timeBCD reaches 8'h00, timeUp=1, running=0 on the same edge as the final tick; held until playEasy drops, then IDLE with all outputs 0.
REQ-037 playMedium, timeBCD=8'h41, mazeDone pulsed on a prescaler-wrap cycle -> win=1, timeBCD stays 8'h41, no tick.
REQ-038 playHard and playMedium both high in IDLE -> stays IDLE, running=0; dropping playMedium -> LOAD with 8'h30.
REQ-039 In RUN, externalReset and mazeDone high in the same cycle -> IDLE, win=0, timeBCD=8'h00.
REQ-040 reset pulsed mid-RUN between clock edges -> outputs 0 without a clock edge; no running until play* is reasserted from IDLE.

Source files
------------

// File: rtl/game_timer.sv
// Maze game countdown: latches a difficulty, loads its BCD start time and
// counts down once per game second until the player wins, loses or quits.
//
// state | meaning
// IDLE  | waiting for exactly one play level; outputs cleared
// LOAD  | one cycle, start time and prescaler loaded
// RUN   | counting down, running high
// WIN   | maze finished in time, win high, time frozen
// LOSE  | time ran out, timeUp high, time shows 00
module game_timer #(
   parameter int         TICKS_PER_SEC = 50000000,
   parameter logic [7:0] HARD_LIMIT    = 8'h30,
   parameter logic [7:0] MEDIUM_LIMIT  = 8'h60,
   parameter logic [7:0] EASY_LIMIT    = 8'h99
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       playHard,
   input  logic       playMedium,
   input  logic       playEasy,
   input  logic       externalReset,
   input  logic       mazeDone,
   output logic [7:0] timeBCD,
   output logic       tick,
   output logic       running,
   output logic       timeUp,
   output logic       win
);

   localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, WIN, LOSE} state_t;
   typedef enum logic [1:0] {LVL_NONE, LVL_HARD, LVL_MEDIUM, LVL_EASY} level_t;

   state_t           state, state_nx;
   level_t           level, level_nx;
   logic [PRE_W-1:0] prescaler, prescaler_nx;
   logic [7:0]       time_nx, dec_val;
   logic             tick_nx, running_nx, timeup_nx, win_nx;
   logic             play_sel, abort, to_idle;

   function automatic logic [7:0] limit_of(input level_t l);
      case (l)
         LVL_HARD:   return HARD_LIMIT;
         LVL_MEDIUM: return MEDIUM_LIMIT;
         LVL_EASY:   return EASY_LIMIT;
         default:    return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] == 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      else
         return {v[7:4], v[3:0] - 4'd1};
   endfunction

   always_comb begin
      case (level)
         LVL_HARD:   play_sel = playHard;
         LVL_MEDIUM: play_sel = playMedium;
         LVL_EASY:   play_sel = playEasy;
         default:    play_sel = 1'b0;
      endcase
   end

   assign abort = externalReset || !play_sel;

   always_comb begin
      state_nx     = state;
      level_nx     = level;
      prescaler_nx = prescaler;
      time_nx      = timeBCD;
      tick_nx      = 1'b0;
      running_nx   = 1'b0;
      timeup_nx    = timeUp;
      win_nx       = win;
      to_idle      = 1'b0;
      dec_val      = bcd_dec(timeBCD);

      case (state)
         IDLE: begin
            to_idle = 1'b1;
            case ({playHard, playMedium, playEasy})
               3'b100:  level_nx = LVL_HARD;
               3'b010:  level_nx = LVL_MEDIUM;
               3'b001:  level_nx = LVL_EASY;
               default: level_nx = LVL_NONE;
            endcase
         end
         LOAD: begin
            if (abort) begin
               to_idle = 1'b1;
            end else begin
               state_nx     = RUN;
               time_nx      = limit_of(level);
               prescaler_nx = '0;
               running_nx   = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               to_idle = 1'b1;
            end else if (mazeDone) begin
               // Finishing wins over a coincident wrap: time stays at its pre-edge value.
               state_nx     = WIN;
               win_nx       = 1'b1;
               prescaler_nx = '0;
            end else if (prescaler == PRE_LAST) begin
               prescaler_nx = '0;
               tick_nx      = 1'b1;
               time_nx      = dec_val;
               if (dec_val == 8'h00) begin
                  state_nx  = LOSE;
                  timeup_nx = 1'b1;
               end else begin
                  running_nx = 1'b1;
               end
            end else begin
               prescaler_nx = prescaler + 1'b1;
               running_nx   = 1'b1;
            end
         end
         WIN, LOSE: begin
            if (abort)
               to_idle = 1'b1;
         end
         default: to_idle = 1'b1;
      endcase

      if (to_idle) begin
         prescaler_nx = '0;
         time_nx      = 8'h00;
         timeup_nx    = 1'b0;
         win_nx       = 1'b0;
         if (state == IDLE && level_nx != LVL_NONE) begin
            // Show the start time already during LOAD.
            state_nx = LOAD;
            time_nx  = limit_of(level_nx);
         end else begin
            state_nx = IDLE;
            level_nx = LVL_NONE;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         level     <= LVL_NONE;
         prescaler <= '0;
         timeBCD   <= 8'h00;
         tick      <= 1'b0;
         running   <= 1'b0;
         timeUp    <= 1'b0;
         win       <= 1'b0;
      end else begin
         state     <= state_nx;
         level     <= level_nx;
         prescaler <= prescaler_nx;
         timeBCD   <= time_nx;
         tick      <= tick_nx;
         running   <= running_nx;
         timeUp    <= timeup_nx;
         win       <= win_nx;
      end
   end

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a seconds-based game model.
module tb_game_timer;

   localparam int T = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       playHard = 1'b0, playMedium = 1'b0, playEasy = 1'b0;
   logic       externalReset = 1'b0, mazeDone = 1'b0;
   logic [7:0] timeBCD;
   logic       tick, running, timeUp, win;

   int checks = 0;
   int failures = 0;

   game_timer #(.TICKS_PER_SEC(T)) dut (
      .clock(clock), .reset(reset),
      .playHard(playHard), .playMedium(playMedium), .playEasy(playEasy),
      .externalReset(externalReset), .mazeDone(mazeDone),
      .timeBCD(timeBCD), .tick(tick), .running(running),
      .timeUp(timeUp), .win(win)
   );

   always #5 clock = ~clock;

   // Model: phase 0 idle, 1 load, 2 run, 3 won, 4 lost; time kept in whole seconds.
   int         m_ph = 0, m_lvl = 0, m_sec = 0, m_age = 0;
   logic [7:0] e_time = 8'h00;
   logic       e_tick = 1'b0, e_run = 1'b0, e_up = 1'b0, e_win = 1'b0;

   function automatic logic [7:0] to_bcd(input int s);
      return {4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic int limit_sec(input int l);
      return (l == 1) ? 30 : (l == 2) ? 60 : 99;
   endfunction

   function automatic logic lvl_on(input int l);
      return (l == 1) ? playHard : (l == 2) ? playMedium : playEasy;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_ph = 0; m_lvl = 0; m_sec = 0; m_age = 0;
         e_time = 8'h00; e_tick = 0; e_run = 0; e_up = 0; e_win = 0;
      end else begin
         e_tick = 0;
         if (m_ph == 0) begin
            if ($countones({playHard, playMedium, playEasy}) == 1) begin
               m_lvl  = playHard ? 1 : playMedium ? 2 : 3;
               m_sec  = limit_sec(m_lvl);
               m_ph   = 1;
               e_time = to_bcd(m_sec);
            end
         end else if (externalReset || !lvl_on(m_lvl)) begin
            m_ph = 0; m_lvl = 0; m_sec = 0;
            e_time = 8'h00; e_run = 0; e_up = 0; e_win = 0;
         end else if (m_ph == 1) begin
            m_ph = 2; m_age = 0; e_run = 1;
         end else if (m_ph == 2) begin
            if (mazeDone) begin
               m_ph = 3; e_win = 1; e_run = 0;
            end else begin
               m_age++;
               if (m_age % T == 0) begin
                  m_sec--;
                  e_tick = 1;
                  e_time = to_bcd(m_sec);
                  if (m_sec == 0) begin
                     m_ph = 4; e_up = 1; e_run = 0;
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         chk("model_timeBCD", timeBCD, e_time);
         chk("model_tick", 8'(tick), 8'(e_tick));
         chk("model_running", 8'(running), 8'(e_run));
         chk("model_timeUp", 8'(timeUp), 8'(e_up));
         chk("model_win", 8'(win), 8'(e_win));
      end
   end

   task automatic wait_for(input string name, input int budget, input int which, input logic [7:0] val);
      bit seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clock);
         if (which == 0) seen = (tick && timeBCD == val);
         else            seen = timeUp;
      end
      if (!seen) begin
         failures++;
         checks++;
         $display("FAIL %s: wait expired after %0d cycles", name, budget);
      end
   endtask

   initial begin
      repeat (2) @(negedge clock);
      chk("rst_timeBCD", timeBCD, 8'h00);
      chk("rst_running", 8'(running), 8'h0);
      chk("rst_win_up_tick", 8'({win, timeUp, tick}), 8'h0);
      reset = 1'b0;
      @(negedge clock);

      // Hard start latency and first ticks
      playHard = 1;
      @(negedge clock);
      chk("lat_load_running", 8'(running), 8'h0);
      @(negedge clock);
      chk("lat_run_running", 8'(running), 8'h1);
      chk("lat_run_time", timeBCD, 8'h30);
      repeat (3) @(negedge clock);
      chk("pre_tick", 8'(tick), 8'h0);
      @(negedge clock);
      chk("tick1", 8'(tick), 8'h1);
      chk("tick1_time", timeBCD, 8'h29);
      repeat (4) @(negedge clock);
      chk("tick2_time", timeBCD, 8'h28);
      playHard = 0;
      @(negedge clock);
      chk("quit_time", timeBCD, 8'h00);

      // Two levels at once stay idle
      playHard = 1; playMedium = 1;
      repeat (3) @(negedge clock);
      chk("dual_running", 8'(running), 8'h0);
      chk("dual_time", timeBCD, 8'h00);
      playMedium = 0;
      @(negedge clock);
      chk("dual_load_time", timeBCD, 8'h30);
      @(negedge clock);
      chk("dual_run", 8'(running), 8'h1);

      // externalReset outranks mazeDone
      @(negedge clock);
      externalReset = 1; mazeDone = 1;
      @(negedge clock);
      externalReset = 0; mazeDone = 0;
      chk("xr_win", 8'(win), 8'h0);
      chk("xr_time", timeBCD, 8'h00);
      playHard = 0;
      @(negedge clock);

      // Medium win on a wrap cycle at 41
      playMedium = 1;
      wait_for("wait_41", 200, 0, 8'h41);
      repeat (3) @(negedge clock);
      mazeDone = 1;
      @(negedge clock);
      mazeDone = 0;
      chk("win_flag", 8'(win), 8'h1);
      chk("win_time", timeBCD, 8'h41);
      chk("win_no_tick", 8'(tick), 8'h0);
      @(negedge clock);
      chk("win_hold_time", timeBCD, 8'h41);
      playMedium = 0;
      @(negedge clock);
      chk("win_clear", 8'(win), 8'h0);

      // Easy runs out
      playEasy = 1;
      wait_for("wait_timeup", 500, 1, 8'h00);
      chk("lose_tick", 8'(tick), 8'h1);
      chk("lose_time", timeBCD, 8'h00);
      chk("lose_running", 8'(running), 8'h0);
      repeat (5) @(negedge clock);
      chk("lose_hold", 8'(timeUp), 8'h1);
      playEasy = 0;
      @(negedge clock);
      chk("lose_clear", 8'({timeUp, win, running, tick}), 8'h0);
      chk("lose_clear_time", timeBCD, 8'h00);

      // Asynchronous reset mid-run
      playHard = 1;
      repeat (6) @(negedge clock);
      chk("pre_async_run", 8'(running), 8'h1);
      #2 reset = 1; playHard = 0;
      #1;
      chk("async_running", 8'(running), 8'h0);
      chk("async_time", timeBCD, 8'h00);
      #1 reset = 0;
      repeat (3) @(negedge clock);
      chk("after_async_idle", 8'(running), 8'h0);
      playHard = 1;
      repeat (2) @(negedge clock);
      chk("after_async_restart", 8'(running), 8'h1);

      // Randomized play
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         if ($urandom_range(39) == 0) begin
            case ($urandom_range(5))
               0: {playHard, playMedium, playEasy} = 3'b000;
               1: {playHard, playMedium, playEasy} = 3'b100;
               2: {playHard, playMedium, playEasy} = 3'b010;
               3: {playHard, playMedium, playEasy} = 3'b001;
               default: {playHard, playMedium, playEasy} = 3'($urandom_range(7));
            endcase
         end
         externalReset = ($urandom_range(149) == 0);
         mazeDone      = ($urandom_range(79) == 0);
      end
      externalReset = 0; mazeDone = 0;
      @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
